// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the data RAM / I-O bus: CPU MEM stage (A) has fixed
// priority, and a burst counter forces a debug-master (B) turn so B never starves.
module dmem_bus_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_stall,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {A_PRI, B_TURN} state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t     state;
  state_t     st_eff;
  logic [3:0] cnt;
  logic [3:0] cnt_eff;
  logic [3:0] cnt_nxt;
  logic       a_vld_p1;
  logic       b_vld_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= BMAX) ? BMAX : v + 4'd1;
  endfunction

  // Stage p0: combinational grant and bus mux. While clr is high the grant
  // logic already sees the post-reset state so the clr cycle behaves like A_PRI.
  always_comb begin
    st_eff  = clr ? A_PRI : state;
    cnt_eff = clr ? 4'd0 : cnt;
    a_gnt   = 1'b0;
    b_gnt   = 1'b0;
    if (st_eff == B_TURN) begin
      b_gnt = b_req;
      a_gnt = a_req & ~b_req;
    end else begin
      a_gnt = a_req;
      b_gnt = b_req & ~a_req;
    end
    cnt_nxt = (a_gnt && b_req) ? sat_inc(cnt_eff) : 4'd0;
  end

  always_comb begin
    mem_we    = (a_gnt & a_we) | (b_gnt & b_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (a_gnt) begin
      mem_addr  = a_addr;
      mem_wdata = a_wdata;
    end else if (b_gnt) begin
      mem_addr  = b_addr;
      mem_wdata = b_wdata;
    end
  end

  assign a_stall = a_req & ~a_gnt;

  // Stage p1: arbitration state and read-valid, one cycle behind the grant.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= A_PRI;
      cnt      <= 4'd0;
      a_vld_p1 <= 1'b0;
      b_vld_p1 <= 1'b0;
    end else begin
      a_vld_p1 <= a_gnt & ~a_we;
      b_vld_p1 <= b_gnt & ~b_we;
      case (state)
        A_PRI: begin
          cnt   <= cnt_nxt;
          state <= (cnt_nxt == BMAX) ? B_TURN : A_PRI;
        end
        default: begin
          cnt   <= 4'd0;
          state <= A_PRI;
        end
      endcase
    end
  end

  assign a_rvalid = a_vld_p1;
  assign b_rvalid = b_vld_p1;
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

endmodule
